// File: rtl/score_pkg.sv
// Shared types and constants for the BCD score counter.
package score_pkg;

  localparam int DIGIT_W    = 5;
  localparam int BCD_MAX    = 9;
  localparam int NUM_DIGITS = 4;

  typedef logic [DIGIT_W-1:0] bcd_digit_t;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

endpackage

// File: rtl/bcd_digit_inc.sv
// One BCD digit incrementer; chained through carry to form a multi-digit counter.
module bcd_digit_inc
  import score_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit_in,
  input  logic               carry_in,
  output logic [DIGIT_W-1:0] digit_out,
  output logic               carry_out
);

  // Anything at or above 9 wraps to 0, so a corrupted digit can never escape the BCD range.
  always_comb begin
    digit_out = digit_in;
    carry_out = 1'b0;
    if (carry_in) begin
      if (digit_in >= bcd_digit_t'(BCD_MAX)) begin
        digit_out = '0;
        carry_out = 1'b1;
      end else begin
        digit_out = digit_in + bcd_digit_t'(1);
      end
    end
  end

endmodule

// File: rtl/score_counter.sv
// 4-digit BCD score counter fed by binary point awards, one point per cycle.
// Define SCORE_COUNTER_HIGH_SCORE_EN to add the hi_* high-score outputs.
module score_counter
  import score_pkg::*;
#(
  parameter int ADD_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic                 clear_score,
  input  logic                 add_valid,
  input  logic [ADD_WIDTH-1:0] add_points,
  output logic                 add_ready,
  output logic [DIGIT_W-1:0]   ones,
  output logic [DIGIT_W-1:0]   tens,
  output logic [DIGIT_W-1:0]   hundreds,
  output logic [DIGIT_W-1:0]   thousands,
`ifdef SCORE_COUNTER_HIGH_SCORE_EN
  output logic [DIGIT_W-1:0]   hi_ones,
  output logic [DIGIT_W-1:0]   hi_tens,
  output logic [DIGIT_W-1:0]   hi_hundreds,
  output logic [DIGIT_W-1:0]   hi_thousands,
`endif
  output logic                 score_changed,
  output logic                 overflow
);

  state_t                 state;
  logic [ADD_WIDTH-1:0]   pending;
  bcd_digit_t             ones_nx, tens_nx, hundreds_nx, thousands_nx;
  logic                   c_ones, c_tens, c_hundreds, c_thousands;
  logic                   score_nonzero;

  bcd_digit_inc u_inc_ones (
    .digit_in  (ones),
    .carry_in  (1'b1),
    .digit_out (ones_nx),
    .carry_out (c_ones)
  );

  bcd_digit_inc u_inc_tens (
    .digit_in  (tens),
    .carry_in  (c_ones),
    .digit_out (tens_nx),
    .carry_out (c_tens)
  );

  bcd_digit_inc u_inc_hundreds (
    .digit_in  (hundreds),
    .carry_in  (c_tens),
    .digit_out (hundreds_nx),
    .carry_out (c_hundreds)
  );

  bcd_digit_inc u_inc_thousands (
    .digit_in  (thousands),
    .carry_in  (c_hundreds),
    .digit_out (thousands_nx),
    .carry_out (c_thousands)
  );

  assign score_nonzero = |{thousands, hundreds, tens, ones};
  assign add_ready     = (state == IDLE);

  // A carry out of the top digit means the score is 9999: saturate instead of wrapping.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state         <= IDLE;
      pending       <= '0;
      ones          <= '0;
      tens          <= '0;
      hundreds      <= '0;
      thousands     <= '0;
      score_changed <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      score_changed <= 1'b0;
      if (clear_score) begin
        state         <= IDLE;
        pending       <= '0;
        ones          <= '0;
        tens          <= '0;
        hundreds      <= '0;
        thousands     <= '0;
        overflow      <= 1'b0;
        score_changed <= score_nonzero;
      end else begin
        case (state)
          IDLE: begin
            if (add_valid) begin
              pending <= add_points;
              if (add_points != '0) begin
                state <= COUNT;
              end
            end
          end
          COUNT: begin
            if (c_thousands) begin
              overflow <= 1'b1;
              pending  <= '0;
              state    <= IDLE;
            end else begin
              ones          <= ones_nx;
              tens          <= tens_nx;
              hundreds      <= hundreds_nx;
              thousands     <= thousands_nx;
              score_changed <= 1'b1;
              pending       <= pending - ADD_WIDTH'(1);
              if (pending == ADD_WIDTH'(1)) begin
                state <= IDLE;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef SCORE_COUNTER_HIGH_SCORE_EN
  // Packed BCD compares correctly as plain binary since every digit stays in 0..9.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      hi_ones      <= '0;
      hi_tens      <= '0;
      hi_hundreds  <= '0;
      hi_thousands <= '0;
    end else if ({thousands, hundreds, tens, ones} >
                 {hi_thousands, hi_hundreds, hi_tens, hi_ones}) begin
      hi_ones      <= ones;
      hi_tens      <= tens;
      hi_hundreds  <= hundreds;
      hi_thousands <= thousands;
    end
  end
`endif

endmodule

// File: tb/tb_score_counter.sv
// Scoreboard bench for score_counter; the monitor checks digits on every score_changed pulse.
module tb_score_counter;

  logic        clk;
  logic        resetN;
  logic        clear_score;
  logic        add_valid;
  logic [7:0]  add_points;
  logic        add_ready;
  logic [4:0]  ones, tens, hundreds, thousands;
  logic        score_changed;
  logic        overflow;
  logic [19:0] score_now;
`ifdef SCORE_COUNTER_HIGH_SCORE_EN
  logic [4:0]  hi_ones, hi_tens, hi_hundreds, hi_thousands;
  logic [19:0] hi_now;
  assign hi_now = {hi_thousands, hi_hundreds, hi_tens, hi_ones};
`endif

  int          tests_run = 0;
  int          errors    = 0;
  int          model_score;
  logic        model_ovf;
  logic [19:0] exp_q[$];

  assign score_now = {thousands, hundreds, tens, ones};

  score_counter #(.ADD_WIDTH(8)) dut (
    .clk           (clk),
    .resetN        (resetN),
    .clear_score   (clear_score),
    .add_valid     (add_valid),
    .add_points    (add_points),
    .add_ready     (add_ready),
    .ones          (ones),
    .tens          (tens),
    .hundreds      (hundreds),
    .thousands     (thousands),
`ifdef SCORE_COUNTER_HIGH_SCORE_EN
    .hi_ones       (hi_ones),
    .hi_tens       (hi_tens),
    .hi_hundreds   (hi_hundreds),
    .hi_thousands  (hi_thousands),
`endif
    .score_changed (score_changed),
    .overflow      (overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [19:0] bcd(input int v);
    bcd = {5'(v / 1000), 5'((v / 100) % 10), 5'((v / 10) % 10), 5'(v % 10)};
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests_run++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Holds the inputs for exactly one rising edge, then returns them to idle.
  task automatic applyStimulus(input logic clr, input logic valid, input logic [7:0] pts);
    clear_score = clr;
    add_valid   = valid;
    add_points  = pts;
    @(posedge clk);
    #1;
    clear_score = 1'b0;
    add_valid   = 1'b0;
    add_points  = 8'd0;
  endtask

  task automatic drainCheck();
    @(negedge clk);
    #1;
    checkOutput("pulses_drained", exp_q.size(), 0);
  endtask

  task automatic award(input int n);
    int incs;
    int exp_low;
    int low;
    if (model_score + n > 9999) begin
      incs    = 9999 - model_score;
      exp_low = incs + 1;
    end else begin
      incs    = n;
      exp_low = n;
    end
    for (int k = 1; k <= incs; k++) exp_q.push_back(bcd(model_score + k));
    if (n > 0 && model_score + n > 9999) model_ovf = 1'b1;
    model_score = model_score + incs;
    applyStimulus(1'b0, 1'b1, n[7:0]);
    low = 0;
    while (add_ready !== 1'b1 && low < 300) begin
      @(posedge clk);
      #1;
      low++;
    end
    checkOutput("ready_low_cycles", low, exp_low);
    checkOutput("digits_after_award", score_now, bcd(model_score));
    checkOutput("overflow_flag", overflow, model_ovf);
    drainCheck();
  endtask

  // Monitor: every score_changed pulse must match the oldest expected score.
  initial begin
    logic [19:0] exp_val;
    forever begin
      @(negedge clk);
      if (resetN === 1'b1 && score_changed === 1'b1) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_score_changed", score_now, 20'hFFFFF);
        end else begin
          exp_val = exp_q.pop_front();
          checkOutput("scoreboard_digits", score_now, exp_val);
        end
      end
    end
  end

  initial begin
    resetN      = 1'b0;
    clear_score = 1'b0;
    add_valid   = 1'b0;
    add_points  = 8'd0;
    model_score = 0;
    model_ovf   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_digits", score_now, 0);
    checkOutput("reset_add_ready", add_ready, 1);
    checkOutput("reset_score_changed", score_changed, 0);
    checkOutput("reset_overflow", overflow, 0);
    resetN = 1'b1;
    @(posedge clk);
    #1;

    award(5);
    award(93);
    award(3);
    for (int i = 0; i < 38; i++) award(255);
    award(206);
    award(10);

    // Clear while idle and saturated, with a competing award that must be dropped.
    exp_q.push_back(bcd(0));
    model_score = 0;
    model_ovf   = 1'b0;
    applyStimulus(1'b1, 1'b1, 8'd4);
    checkOutput("clear_idle_digits", score_now, 0);
    checkOutput("clear_idle_overflow", overflow, 0);
    checkOutput("clear_idle_ready", add_ready, 1);
    @(posedge clk);
    #1;
    checkOutput("clear_idle_ignored_ready", add_ready, 1);
    checkOutput("clear_idle_ignored_digits", score_now, 0);
    drainCheck();

    award(7);
    award(0);

    // Clear in the middle of a 200-point award.
    for (int k = 1; k <= 50; k++) exp_q.push_back(bcd(model_score + k));
    applyStimulus(1'b0, 1'b1, 8'd200);
    repeat (50) @(posedge clk);
    #1;
    checkOutput("midcount_busy", add_ready, 0);
    checkOutput("midcount_digits", score_now, bcd(57));
    exp_q.push_back(bcd(0));
    model_score = 0;
    applyStimulus(1'b1, 1'b1, 8'd9);
    checkOutput("midclear_digits", score_now, 0);
    checkOutput("midclear_ready", add_ready, 1);
    checkOutput("midclear_overflow", overflow, 0);
    @(posedge clk);
    #1;
    checkOutput("midclear_ignored_ready", add_ready, 1);
    checkOutput("midclear_ignored_digits", score_now, 0);
    drainCheck();

    // Asynchronous reset mid-award kills the in-flight pulse and the pending points.
    for (int k = 1; k <= 3; k++) exp_q.push_back(bcd(k));
    applyStimulus(1'b0, 1'b1, 8'd20);
    repeat (4) @(posedge clk);
    #1;
    resetN = 1'b0;
    #1;
    checkOutput("async_reset_digits", score_now, 0);
    checkOutput("async_reset_ready", add_ready, 1);
    checkOutput("async_reset_pulse", score_changed, 0);
    @(posedge clk);
    #1;
    resetN = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("after_reset_ready", add_ready, 1);
    checkOutput("after_reset_digits", score_now, 0);
    drainCheck();
    model_score = 0;
    model_ovf   = 1'b0;

`ifdef SCORE_COUNTER_HIGH_SCORE_EN
    award(42);
    @(posedge clk);
    #1;
    checkOutput("hi_after_42", hi_now, bcd(42));
    exp_q.push_back(bcd(0));
    model_score = 0;
    applyStimulus(1'b1, 1'b0, 8'd0);
    drainCheck();
    award(7);
    @(posedge clk);
    #1;
    checkOutput("hi_kept_after_clear", hi_now, bcd(42));
`endif

    checkOutput("final_queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, errors);
    $finish;
  end

endmodule
